// File: rtl/fetch_stage_ctrl_if.sv
// fetch_stage_ctrl_if: control, instruction-memory and IF/ID signals of the fetch stage
interface fetch_stage_ctrl_if #(parameter int CNT_W = 16);
  logic             PCWrite_i;
  logic             Stall_i;
  logic             Flush_i;
  logic [31:0]      BranchTarget_i;
  logic [31:0]      IMem_Instr_i;
  logic [31:0]      PC_o;
  logic [31:0]      ID_PC_o;
  logic [31:0]      ID_Instr_o;
  logic             ID_Valid_o;
  logic [CNT_W-1:0] StallCnt_o;
  logic [CNT_W-1:0] FlushCnt_o;
  modport master (output PCWrite_i, Stall_i, Flush_i, BranchTarget_i, IMem_Instr_i,
                  input PC_o, ID_PC_o, ID_Instr_o, ID_Valid_o, StallCnt_o, FlushCnt_o);
  modport slave (input PCWrite_i, Stall_i, Flush_i, BranchTarget_i, IMem_Instr_i,
                 output PC_o, ID_PC_o, ID_Instr_o, ID_Valid_o, StallCnt_o, FlushCnt_o);
endinterface

// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: PC and IF/ID register under PCWrite/Stall/Flush control, with event counters
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input logic clk_i,
  input logic rst_i,
  fetch_stage_ctrl_if.slave bus
);
  logic [31:0]      pc_q, pc_d, id_pc_q, id_pc_d, id_instr_q, id_instr_d;
  logic             id_valid_q, id_valid_d;
  logic [CNT_W-1:0] scnt_q, scnt_d, fcnt_q, fcnt_d;
  logic             eff_flush;
  // Next state: a stall suppresses the flush; PCWrite alone gates the PC.
  always_comb begin
    eff_flush  = bus.Flush_i && !bus.Stall_i;
    pc_d       = !bus.PCWrite_i ? pc_q : eff_flush ? bus.BranchTarget_i : pc_q + 32'd4;
    id_pc_d    = bus.Stall_i ? id_pc_q : pc_q;
    id_instr_d = bus.Stall_i ? id_instr_q : bus.Flush_i ? NOP_INSTR : bus.IMem_Instr_i;
    id_valid_d = bus.Stall_i ? id_valid_q : !bus.Flush_i;
    scnt_d     = scnt_q + CNT_W'(bus.Stall_i && !(&scnt_q));
    fcnt_d     = fcnt_q + CNT_W'(eff_flush && !(&fcnt_q));
  end
  // State registers; reset wins over every control input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      scnt_q     <= '0;
      fcnt_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      scnt_q     <= scnt_d;
      fcnt_q     <= fcnt_d;
    end
  end
  assign bus.PC_o       = pc_q;
  assign bus.ID_PC_o    = id_pc_q;
  assign bus.ID_Instr_o = id_instr_q;
  assign bus.ID_Valid_o = id_valid_q;
  assign bus.StallCnt_o = scnt_q;
  assign bus.FlushCnt_o = fcnt_q;
endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// tb_fetch_stage_ctrl: directed vectors with a queued scoreboard checked by a monitor
module tb_fetch_stage_ctrl;
  localparam logic [31:0] I   = 32'h00A0_0093;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] idpc;
    logic [31:0] ins;
    logic        v;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int   checks = 0, passed = 0;
  exp_t q[$];
  fetch_stage_ctrl_if #(.CNT_W(16)) bus ();
  fetch_stage_ctrl #(.CNT_W(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic cyc(input logic r, pw, s, f, input logic [31:0] t, input logic chk,
                     input logic [31:0] epc, eidpc, eins, input logic ev, input logic [15:0] esc, efc);
    rst = r;
    bus.PCWrite_i = pw;
    bus.Stall_i = s;
    bus.Flush_i = f;
    bus.BranchTarget_i = t;
    @(posedge clk);
    #1;
    if (chk) q.push_back('{epc, eidpc, eins, ev, esc, efc});
  endtask
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = '{bus.PC_o, bus.ID_PC_o, bus.ID_Instr_o, bus.ID_Valid_o, bus.StallCnt_o, bus.FlushCnt_o};
      checks++;
      if (a == e) passed++;
      else $display("FAIL state#%0d: got pc=%h idpc=%h ins=%h v=%b sc=%0d fc=%0d, want pc=%h idpc=%h ins=%h v=%b sc=%0d fc=%0d",
                    checks, a.pc, a.idpc, a.ins, a.v, a.sc, a.fc, e.pc, e.idpc, e.ins, e.v, e.sc, e.fc);
    end
  end
  initial begin
    bus.IMem_Instr_i = I;
    cyc(1, 1, 0, 0, 0, 1, 32'h0, 32'h0, NOP, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 32'h4, 32'h0, I, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 32'h8, 32'h4, I, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 32'h8, 32'h4, I, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 1, 32'hC, 32'h8, I, 1, 1, 0);
    cyc(0, 1, 0, 1, 32'h40, 1, 32'h40, 32'hC, NOP, 0, 1, 1);
    cyc(0, 1, 0, 0, 0, 1, 32'h44, 32'h40, I, 1, 1, 1);
    cyc(0, 0, 1, 1, 32'h80, 1, 32'h44, 32'h40, I, 1, 2, 1);
    cyc(0, 1, 0, 1, 32'h80, 1, 32'h80, 32'h44, NOP, 0, 2, 2);
    cyc(0, 1, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h80, NOP, 0, 2, 3);
    cyc(0, 1, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC, I, 1, 2, 3);
    cyc(0, 1, 1, 0, 0, 1, 32'h4, 32'hFFFF_FFFC, I, 1, 3, 3);
    cyc(0, 0, 1, 0, 0, 1, 32'h4, 32'hFFFF_FFFC, I, 1, 4, 3);
    cyc(1, 0, 1, 1, 32'h123, 1, 32'h0, 32'h0, NOP, 0, 0, 0);
    for (int k = 1; k <= 65541; k++) begin
      logic [15:0] sc;
      sc = (k > 65535) ? 16'hFFFF : 16'(k);
      cyc(0, 0, 1, 0, 0, (k <= 2) || (k >= 65534 && k <= 65536) || k == 65541,
          32'h0, 32'h0, NOP, 0, sc, 0);
    end
    cyc(0, 1, 0, 1, 32'h200, 1, 32'h200, 32'h0, NOP, 0, 16'hFFFF, 1);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
- Consumer side of the load-use hazard handshake.
- Owns the program counter and the IF/ID pipeline register, and applies the PCWrite / Stall / Flush controls that the hazard and branch logic drive.
- Sits between instruction memory and the ID stage.
- Also keeps saturating stall and flush event counters for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction inserted into IF/ID on flush or reset (addi x0,x0,0).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- PCWrite_i  input  1  1 = PC may advance; 0 = hold PC (from hazard detection).
- Stall_i  input  1  1 = hold IF/ID contents (from hazard detection).
- Flush_i  input  1  1 = branch taken in ID; redirect PC and squash IF/ID.
- BranchTarget_i  input  32  redirect address, valid when Flush_i=1.
- IMem_Instr_i  input  32  instruction read combinationally at PC_o.
- PC_o  output  32  current fetch address (to instruction memory).
- ID_PC_o  output  32  PC of the instruction held in IF/ID.
- ID_Instr_o  output  32  instruction held in IF/ID.
- ID_Valid_o  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
- StallCnt_o  output  CNT_W  number of cycles with an effective stall, saturating.
- FlushCnt_o  output  CNT_W  number of effective flushes, saturating.

Behaviour:
- Reset (rst_i=1 at an edge):
  - PC_o=RESET_PC, ID_PC_o=0, ID_Instr_o=NOP_INSTR, ID_Valid_o=0, both counters=0.
  - Reset overrides every other input in the same cycle.
- Per-cycle priority after reset: stall > flush > normal.
- stall condition = Stall_i=1 or PCWrite_i=0.
- Stall (stall condition true):
  - If PCWrite_i=0, PC holds; otherwise PC follows the normal or flush rule.
  - If Stall_i=1, IF/ID holds ID_PC_o, ID_Instr_o and ID_Valid_o unchanged.
  - StallCnt_o increments by 1 if Stall_i=1.
- Flush_i=1 together with Stall_i=1: flush is ignored this cycle.
  - Rationale: the branch in ID is using stale load data and is re-evaluated next cycle.
  - FlushCnt_o does not increment.
- Effective flush (Flush_i=1, Stall_i=0):
  - PC <= BranchTarget_i if PCWrite_i=1, else PC holds.
  - IF/ID <= {PC_o, NOP_INSTR, valid=0}.
  - FlushCnt_o increments by 1.
- Normal (all controls inactive, PCWrite_i=1): PC <= PC_o+4 (32-bit wrap, 32'hFFFF_FFFC -> 0); IF/ID <= {PC_o, IMem_Instr_i, valid=1}.
- Mismatched control pairs:
  - PCWrite_i=0 with Stall_i=0: PC holds while IF/ID loads normally, so the same instruction is captured twice. This is legal and not checked.
  - PCWrite_i=1 with Stall_i=1: IF/ID holds while PC advances. Legal, but the fetched instruction is lost; upstream must not drive this combination.
- Counters saturate at all ones and never wrap.
- Latency:
  - Redirect takes 1 cycle: PC_o shows BranchTarget_i on the cycle after Flush_i.
  - The target instruction reaches ID_Instr_o 2 cycles after Flush_i.
- Outputs are registered; there is no combinational path from any input to any output.
- BranchTarget_i low two bits are used as given; no alignment check.

Test Plan:
- Reset then 4 free-running cycles, IMem returns 32'h00A00093 constant:
  - PC_o goes 0 -> 4 -> 8 -> C.
  - ID_Valid_o goes 0 -> 1.
  - ID_PC_o tracks the previous PC_o.
- Load-use stall, PCWrite_i=0 and Stall_i=1 for 1 cycle at PC_o=8:
  - PC_o stays 8 for 2 consecutive cycles.
  - ID_PC_o stays 4 for 2 cycles.
  - StallCnt_o=1.
- Flush_i=1, BranchTarget_i=32'h40 at PC_o=C:
  - Next cycle PC_o=40, ID_Instr_o=32'h00000013, ID_Valid_o=0, FlushCnt_o=1.
  - Following cycle ID_PC_o=40, ID_Valid_o=1.
- Flush_i=1 with Stall_i=1 and PCWrite_i=0, BranchTarget_i=32'h80:
  - PC and IF/ID are held.
  - FlushCnt_o unchanged, StallCnt_o +1.
  - Next cycle Flush_i=1 alone: PC_o=80.
- PC wrap: force PC_o to 32'hFFFFFFFC via flush, then run 1 normal cycle: PC_o=0.
- Reset asserted mid-stall with Flush_i=1:
  - Next cycle all outputs equal their reset values.
  - Counters return to 0.
  - Stall_i held 2^CNT_W+5 cycles: StallCnt_o saturates at all ones.
